// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: control inputs, instruction-memory port and IF/ID outputs.
// The slave side is the fetch unit; the master side is the pipeline/memory.
interface fetch_unit_if #(
  parameter int unsigned PC_W = 32
);
  logic            START;
  logic            STALL;
  logic            REDIRECT;
  logic [PC_W-1:0] REDIRECT_PC;
  logic [31:0]     INSTRUCTION;
  logic [31:0]     ADDRESS;
  logic [31:0]     IF_ID_INSTR;
  logic [PC_W-1:0] IF_ID_PC;
  logic            IF_ID_VALID;
  logic            HALTED;
  logic [15:0]     FETCH_COUNT;

  modport slave (
    input  START, STALL, REDIRECT, REDIRECT_PC, INSTRUCTION,
    output ADDRESS, IF_ID_INSTR, IF_ID_PC, IF_ID_VALID, HALTED, FETCH_COUNT
  );

  modport master (
    output START, STALL, REDIRECT, REDIRECT_PC, INSTRUCTION,
    input  ADDRESS, IF_ID_INSTR, IF_ID_PC, IF_ID_VALID, HALTED, FETCH_COUNT
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, registers fetched words into IF/ID,
// handles stall, redirect-with-flush and halt on the end-of-program zero word.
//   state  | meaning
//   S_IDLE | waiting for START, no fetch
//   S_RUN  | fetching one word per unstalled cycle
//   S_HALT | zero word seen, waiting for a redirect
module fetch_unit #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned RESET_PC     = 0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic         CLK,
  input  logic         RST_N,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] L_RESET_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] L_PC_ONE   = PC_W'(1);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_ifpc;
  logic            r_valid;
  logic [15:0]     r_cnt;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [31:0]     w_instr_nxt;
  logic [PC_W-1:0] w_ifpc_nxt;
  logic            w_valid_nxt;
  logic [15:0]     w_cnt_nxt;
  logic            w_zero_word;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_pc    <= L_RESET_PC;
      r_instr <= 32'h0;
      r_ifpc  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_ifpc  <= w_ifpc_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_ifpc_nxt  = r_ifpc;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    w_zero_word = HALT_ON_ZERO && (bus.INSTRUCTION == 32'h0);

    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (bus.START) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = L_RESET_PC;
        end
      end
      S_RUN: begin
        // Redirect outranks everything: the word at the current PC is wrong-path.
        if (bus.REDIRECT) begin
          w_pc_nxt    = bus.REDIRECT_PC;
          w_valid_nxt = 1'b0;
        end else if (bus.STALL) begin
          w_state_nxt = S_RUN;
        end else if (w_zero_word) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_HALT;
        end else begin
          w_instr_nxt = bus.INSTRUCTION;
          w_ifpc_nxt  = r_pc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + L_PC_ONE;
          w_cnt_nxt   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        end
      end
      S_HALT: begin
        w_valid_nxt = 1'b0;
        if (bus.REDIRECT) begin
          w_pc_nxt    = bus.REDIRECT_PC;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.ADDRESS     = 32'(r_pc);
  assign bus.IF_ID_INSTR = r_instr;
  assign bus.IF_ID_PC    = r_ifpc;
  assign bus.IF_ID_VALID = r_valid;
  assign bus.HALTED      = (r_state == S_HALT);
  assign bus.FETCH_COUNT = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table through a scoreboard queue, then async reset
// and a narrow-PC instance for wrap-around and FETCH_COUNT saturation.
module tb_fetch_unit;

  typedef struct {
    bit          start;
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_ifpc;
    bit          exp_valid;
    bit          exp_halt;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [31:0] imem [0:15];
  vec_t tbl [$];
  vec_t sb  [$];

  fetch_unit_if #(.PC_W(32)) bus ();
  fetch_unit_if #(.PC_W(4))  bus4 ();

  fetch_unit #(.PC_W(32), .RESET_PC(0), .HALT_ON_ZERO(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  fetch_unit #(.PC_W(4), .RESET_PC(15), .HALT_ON_ZERO(1'b0)) dut4 (
    .CLK(clk), .RST_N(rst_n), .bus(bus4)
  );

  assign bus.INSTRUCTION  = (bus.ADDRESS < 32'd16) ? imem[bus.ADDRESS[3:0]] : 32'h0;
  assign bus4.INSTRUCTION = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit st, input bit sl, input bit rd, input int rpc,
                              input int addr, input int ifpc, input bit vld,
                              input bit hlt, input int cnt);
    vec_t v;
    v.start = st; v.stall = sl; v.redir = rd; v.rpc = rpc;
    v.exp_addr = addr; v.exp_ifpc = ifpc; v.exp_valid = vld;
    v.exp_halt = hlt; v.exp_cnt = 16'(cnt);
    return v;
  endfunction

  task automatic check_main(input string tag, input vec_t e);
    logic [31:0] exp_instr;
    exp_instr = (e.exp_cnt == 16'h0) ? 32'h0 : 32'h1000_0000 + e.exp_ifpc;
    chk({tag, " addr"},  bus.ADDRESS, e.exp_addr);
    chk({tag, " ifpc"},  bus.IF_ID_PC, e.exp_ifpc);
    chk({tag, " valid"}, 32'(bus.IF_ID_VALID), 32'(e.exp_valid));
    chk({tag, " halt"},  32'(bus.HALTED), 32'(e.exp_halt));
    chk({tag, " cnt"},   32'(bus.FETCH_COUNT), 32'(e.exp_cnt));
    chk({tag, " instr"}, bus.IF_ID_INSTR, exp_instr);
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    bus.START       = v.start;
    bus.STALL       = v.stall;
    bus.REDIRECT    = v.redir;
    bus.REDIRECT_PC = v.rpc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_main($sformatf("v%0d", idx), e);
  endtask

  task automatic check4(input string tag, input logic [31:0] addr, input logic [3:0] ifpc,
                        input bit vld, input logic [15:0] cnt);
    chk({tag, " addr"},  bus4.ADDRESS, addr);
    chk({tag, " ifpc"},  32'(bus4.IF_ID_PC), 32'(ifpc));
    chk({tag, " valid"}, 32'(bus4.IF_ID_VALID), 32'(vld));
    chk({tag, " cnt"},   32'(bus4.FETCH_COUNT), 32'(cnt));
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) imem[i] = (i < 9) ? 32'h1000_0000 + 32'(i) : 32'h0;
    bus.START = 0; bus.STALL = 0; bus.REDIRECT = 0; bus.REDIRECT_PC = 0;
    bus4.START = 0; bus4.STALL = 0; bus4.REDIRECT = 0; bus4.REDIRECT_PC = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_main("reset", v);

    // run program 0..8, halt at 9, restart, redirects, stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) tbl.push_back(mk(0, 0, 0, 0, k, k - 1, 1, 0, k));
    tbl.push_back(mk(0, 0, 0, 0, 9, 8, 0, 1, 9));
    tbl.push_back(mk(1, 1, 0, 0, 9, 8, 0, 1, 9));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8, 0, 0, 9));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0, 11));
    tbl.push_back(mk(0, 0, 1, 7, 7, 1, 0, 0, 11));
    tbl.push_back(mk(0, 0, 0, 0, 8, 7, 1, 0, 12));
    tbl.push_back(mk(0, 0, 0, 0, 9, 8, 1, 0, 13));
    tbl.push_back(mk(0, 0, 1, 2, 2, 8, 0, 0, 13));
    tbl.push_back(mk(0, 1, 1, 7, 7, 8, 0, 0, 13));
    tbl.push_back(mk(0, 0, 0, 0, 8, 7, 1, 0, 14));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7, 0, 0, 14));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 0, k + 1, k, 1, 0, 15 + k));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 0, 4, 3, 1, 0, 18));
    tbl.push_back(mk(0, 0, 0, 0, 5, 4, 1, 0, 19));
    foreach (tbl[i]) apply(tbl[i], i);

    // asynchronous reset in the middle of a cycle, ADDRESS=5
    bus.START = 0; bus.STALL = 0; bus.REDIRECT = 0;
    #2;
    rst_n = 1'b0;
    #1;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_main("async_rst", v);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 101);
    apply(mk(0, 0, 0, 0, 1, 0, 1, 0, 1), 102);

    // narrow PC: wrap 15 -> 0, zero words forwarded, counter saturates
    @(negedge clk);
    bus4.START = 1;
    @(posedge clk); #1;
    check4("w_start", 32'h0000_000F, 4'h0, 0, 16'h0);
    @(negedge clk);
    bus4.START = 0;
    @(posedge clk); #1;
    check4("w_first", 32'h0, 4'hF, 1, 16'd1);
    chk("w_instr", bus4.IF_ID_INSTR, 32'h0);
    @(posedge clk); #1;
    check4("w_second", 32'h1, 4'h0, 1, 16'd2);
    repeat (65532) @(posedge clk);
    #1;
    check4("w_fffe", 32'd13, 4'd12, 1, 16'hFFFE);
    @(posedge clk); #1;
    check4("w_ffff", 32'd14, 4'd13, 1, 16'hFFFF);
    @(posedge clk); #1;
    check4("w_sat", 32'd15, 4'd14, 1, 16'hFFFF);
    @(posedge clk); #1;
    check4("w_sat2", 32'd0, 4'd15, 1, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
